// File: rtl/opb_sequencer.sv
// opb_sequencer: multicycle sequencer for the ALU B-operand path.
// It accepts one operation at a time, optionally fetches a data-memory
// operand under a bounded wait, then drives the B-source select while
// strobing ALU enable and, optionally, register write-back.

module opb_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_src,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_wb,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              dm_le,
    output logic [1:0]        sel_b,
    output logic              alu_en,
    output logic              reg_we,
    output logic              busy,
    input  logic              err_clr,
    output logic              timeout_err
);

    // Wide enough to hold TIMEOUT itself; the counter stops there and never wraps.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MEMRD = 2'b01,
        EXEC  = 2'b10,
        WB    = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wb_q, wb_d;
    logic              err_q, err_d;

    logic              ready_q;
    logic              req_q;
    logic              alu_q;
    logic              we_q;
    logic              busy_q;
    logic [1:0]        sel_q;

    logic              ackHit;
    logic              timeoutHit;

    // A memory ack only counts while a read is outstanding; an ack in the
    // final wait cycle takes priority over the timeout.
    assign ackHit     = (state_q == MEMRD) && mem_ack;
    assign timeoutHit = (state_q == MEMRD) && !mem_ack && (cnt_q == CNT_MAX);

    // Next-state, operation latches, wait counter and sticky error flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        addr_d  = addr_q;
        wb_d    = wb_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d  = in_src;
                    addr_d = in_addr;
                    wb_d   = in_wb;
                    if (in_src == SRC_MEM) begin
                        state_d = MEMRD;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            MEMRD: begin
                if (mem_ack) begin
                    state_d = EXEC;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EXEC: begin
                state_d = wb_q ? WB : IDLE;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeoutHit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, latches and Moore outputs; outputs are decoded from the next
    // state so they become flops that line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= 2'b00;
            addr_q  <= '0;
            wb_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            req_q   <= 1'b0;
            alu_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= SRC_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
            ready_q <= (state_d == IDLE);
            req_q   <= (state_d == MEMRD);
            alu_q   <= (state_d == EXEC);
            we_q    <= (state_d == WB);
            busy_q  <= (state_d != IDLE);
            sel_q   <= ((state_d == EXEC) || (state_d == WB)) ? src_d : SRC_ZERO;
        end
    end

    assign in_ready    = ready_q;
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign dm_le       = ackHit;
    assign sel_b       = sel_q;
    assign alu_en      = alu_q;
    assign reg_we      = we_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_opb_sequencer.sv
// Self-checking bench for opb_sequencer: directed scenarios followed by
// randomized traffic, all checked against a plan-based reference model.

module tb_opb_sequencer;

    localparam int AW  = 8;
    localparam int TMO = 15;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_src;
    logic [AW-1:0] in_addr;
    logic          in_wb;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          dm_le;
    logic [1:0]    sel_b;
    logic          alu_en;
    logic          reg_we;
    logic          busy;
    logic          err_clr;
    logic          timeout_err;

    opb_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src      (in_src),
        .in_addr     (in_addr),
        .in_wb       (in_wb),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .dm_le       (dm_le),
        .sel_b       (sel_b),
        .alu_en      (alu_en),
        .reg_we      (reg_we),
        .busy        (busy),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle of a planned operation. An empty plan means idle.
    typedef struct packed {
        logic       memReq;
        logic       dmLe;
        logic       ack;
        logic [1:0] sel;
        logic       alu;
        logic       we;
        logic       tmo;
    } step_t;

    step_t         plan[$];
    logic          expErr;
    logic [AW-1:0] expAddr;
    int            tests;
    int            fails;

    logic          obsReady;
    logic          obsReq;
    logic          obsDmLe;
    logic          obsAlu;
    logic          obsWe;
    logic          obsErr;
    logic [1:0]    obsSel;
    logic [AW-1:0] obsAddr;

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // An accepted operation becomes a timeline of expected cycles. ackDelay
    // is the MEMRD cycle carrying the ack (1..TMO); 0 means never ack.
    task automatic buildPlan(input logic [1:0] src, input logic wb, input int ackDelay);
        step_t s;
        int n;
        if (src == 2'b01) begin
            n = (ackDelay == 0) ? TMO : ackDelay;
            for (int i = 1; i <= n; i++) begin
                s = '{memReq: 1'b1, dmLe: 1'b0, ack: 1'b0, sel: 2'b11, alu: 1'b0, we: 1'b0, tmo: 1'b0};
                s.ack  = (ackDelay != 0) && (i == n);
                s.dmLe = s.ack;
                s.tmo  = (ackDelay == 0) && (i == n);
                plan.push_back(s);
            end
            if (ackDelay == 0) return;
        end
        s = '{memReq: 1'b0, dmLe: 1'b0, ack: 1'b0, sel: src, alu: 1'b1, we: 1'b0, tmo: 1'b0};
        plan.push_back(s);
        if (wb) begin
            s = '{memReq: 1'b0, dmLe: 1'b0, ack: 1'b0, sel: src, alu: 1'b0, we: 1'b1, tmo: 1'b0};
            plan.push_back(s);
        end
    endtask

    // Drive one cycle of inputs, check every output against the model, then
    // advance the model. stray is the mem_ack value used outside reads.
    task automatic applyStimulus(input logic v, input logic [1:0] src, input logic [AW-1:0] addr,
                                 input logic wb, input int ackDelay, input logic stray, input logic clr);
        step_t e;
        logic idle;
        logic accept;
        @(negedge clk);
        idle   = (plan.size() == 0);
        accept = idle && v;
        if (idle) e = '{memReq: 1'b0, dmLe: 1'b0, ack: 1'b0, sel: 2'b11, alu: 1'b0, we: 1'b0, tmo: 1'b0};
        else      e = plan.pop_front();
        in_valid = v;
        in_src   = src;
        in_addr  = addr;
        in_wb    = wb;
        err_clr  = clr;
        mem_ack  = e.memReq ? e.ack : stray;
        #1;
        obsReady = in_ready;
        obsReq   = mem_req;
        obsDmLe  = dm_le;
        obsAlu   = alu_en;
        obsWe    = reg_we;
        obsErr   = timeout_err;
        obsSel   = sel_b;
        obsAddr  = mem_addr;
        checkOutput("in_ready", in_ready, idle);
        checkOutput("busy", busy, !idle);
        checkOutput("mem_req", mem_req, e.memReq);
        checkOutput("dm_le", dm_le, e.dmLe);
        checkOutput("sel_b", sel_b, e.sel);
        checkOutput("alu_en", alu_en, e.alu);
        checkOutput("reg_we", reg_we, e.we);
        checkOutput("mem_addr", mem_addr, expAddr);
        checkOutput("timeout_err", timeout_err, expErr);
        if (e.tmo)      expErr = 1'b1;
        else if (clr)   expErr = 1'b0;
        if (accept) begin
            expAddr = addr;
            buildPlan(src, wb, ackDelay);
        end
    endtask

    // Run idle cycles until the model has no planned work left.
    task automatic drain();
        for (int i = 0; i < 40 && plan.size() != 0; i++)
            applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Hard stop if anything ever hangs.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        int reqCount;
        int dmCount;
        int aluCount;
        int weCount;
        int acceptCount;
        logic [1:0] rSrc;
        int rDelay;

        tests    = 0;
        fails    = 0;
        expErr   = 1'b0;
        expAddr  = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_src   = 2'b00;
        in_addr  = '0;
        in_wb    = 1'b0;
        mem_ack  = 1'b0;
        err_clr  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_dm_le", dm_le, 0);
        checkOutput("rst_sel_b", sel_b, 2'b11);
        checkOutput("rst_alu_en", alu_en, 0);
        checkOutput("rst_reg_we", reg_we, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Literal source with write-back.
        applyStimulus(1'b1, 2'b10, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("pin_lit_alu", obsAlu, 1);
        checkOutput("pin_lit_sel_exec", obsSel, 2'b10);
        applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("pin_lit_we", obsWe, 1);
        checkOutput("pin_lit_sel_wb", obsSel, 2'b10);
        applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("pin_lit_ready", obsReady, 1);
        checkOutput("pin_lit_sel_idle", obsSel, 2'b11);

        // Memory operand, ack on the third read cycle.
        reqCount = 0; dmCount = 0; aluCount = 0;
        applyStimulus(1'b1, 2'b01, 8'h3C, 1'b0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
            reqCount += int'(obsReq);
            dmCount  += int'(obsDmLe);
            aluCount += int'(obsAlu);
            if (i == 0) checkOutput("pin_mem_addr", obsAddr, 8'h3C);
            if (i == 3) checkOutput("pin_mem_exec_sel", obsSel, 2'b01);
        end
        checkOutput("pin_mem_req_cycles", reqCount, 3);
        checkOutput("pin_mem_dmle_cycles", dmCount, 1);
        checkOutput("pin_mem_alu_cycles", aluCount, 1);

        // Timeout with no ack, followed by a normal register-source op.
        reqCount = 0; aluCount = 0; weCount = 0;
        applyStimulus(1'b1, 2'b01, 8'h55, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < TMO + 2; i++) begin
            applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
            reqCount += int'(obsReq);
            aluCount += int'(obsAlu);
            weCount  += int'(obsWe);
        end
        checkOutput("pin_tmo_req_cycles", reqCount, TMO);
        checkOutput("pin_tmo_alu_cycles", aluCount, 0);
        checkOutput("pin_tmo_we_cycles", weCount, 0);
        checkOutput("pin_tmo_err", obsErr, 1);
        applyStimulus(1'b1, 2'b00, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        drain();

        // Clear the flag, then an ack in the very last allowed cycle.
        applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b1);
        aluCount = 0;
        applyStimulus(1'b1, 2'b01, 8'hA0, 1'b0, TMO, 1'b0, 1'b0);
        for (int i = 0; i < TMO + 2; i++) begin
            applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
            aluCount += int'(obsAlu);
        end
        checkOutput("pin_lastack_alu", aluCount, 1);
        checkOutput("pin_lastack_err", obsErr, 0);

        // err_clr coinciding with the timeout cycle must lose.
        applyStimulus(1'b1, 2'b01, 8'h11, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= TMO; i++)
            applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, (i == TMO));
        applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("pin_setwins_err", obsErr, 1);

        // Asynchronous reset in the middle of a memory read.
        applyStimulus(1'b1, 2'b01, 8'h77, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 2'b00, '0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("pin_arst_before", obsReq, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_mem_req", mem_req, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        checkOutput("arst_sel_b", sel_b, 2'b11);
        checkOutput("arst_mem_addr", mem_addr, 0);
        checkOutput("arst_timeout_err", timeout_err, 0);
        checkOutput("arst_alu_we", {alu_en, reg_we, dm_le}, 0);
        plan.delete();
        expErr  = 1'b0;
        expAddr = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid held high with stray acks: one acceptance every 2 cycles.
        acceptCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'b00, 8'h5A, 1'b0, 0, 1'b1, 1'b0);
            acceptCount += int'(obsReady);
        end
        checkOutput("pin_b2b_accepts", acceptCount, 10);
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rSrc   = 2'($urandom_range(0, 3));
            rDelay = (rSrc == 2'b01) ? $urandom_range(0, TMO) : 0;
            applyStimulus(1'($urandom_range(0, 1)), rSrc, AW'($urandom), 1'($urandom_range(0, 1)),
                          rDelay, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
